// File: rtl/msk_fifo.sv
// Masked-entry FIFO. It stores d-share masked words verbatim and never combines
// the shares of a bit. Entries are zeroed on pop, on flush and on reset, so no
// share data lingers in a slot that has been freed.
module msk_fifo #(
    parameter int d     = 2,
    parameter int count = 8,
    parameter int DEPTH = 4,
    localparam int W    = count * d,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [AW:0]  level
);

    localparam logic [AW:0] FULL = DEPTH[AW:0];

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wptr;
    logic [AW-1:0]           rptr;
    logic                    push;
    logic                    pop;

    // Handshakes are taken only from registered occupancy, so neither ready
    // nor valid depends on the other side in the same cycle.
    assign in_ready  = (level != FULL);
    assign out_valid = (level != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // The head is exposed only while valid, so an empty FIFO drives zero.
    assign out_data  = out_valid ? mem[rptr] : '0;

    // Pointers and occupancy. Flush wins over any handshake in that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

    // Entry storage. Push and pop never address the same slot in one cycle:
    // the pointers are equal only when the FIFO is empty (no pop possible) or
    // full (no push possible).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (flush) begin
            mem <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && wptr == AW'(i))     mem[i] <= in_data;
                else if (pop && rptr == AW'(i)) mem[i] <= '0;
            end
        end
    end

endmodule

// File: doc/msk_fifo.md
MSK_FIFO -- requirements
Module: msk_fifo

Interface
REQ-001 SHALL have parameter d, default 2, meaning number of shares per masked bit.
REQ-002 SHALL have parameter count, default 8, meaning number of masked bits per entry; entry width W = count*d, share-major layout unchanged from the masked bus convention.
REQ-003 SHALL have parameter DEPTH, default 4, meaning number of entries; legal values are powers of two, 2 to 64.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset: asynchronous assert, active-low.
REQ-006 SHALL have port flush, input, 1, synchronous clear of all entries.
REQ-007 SHALL have port in_data, input, W, masked entry to push.
REQ-008 SHALL have port in_valid, input, 1, push request.
REQ-009 SHALL have port in_ready, output, 1, FIFO can accept an entry.
REQ-010 SHALL have port out_data, output, W, head entry shares.
REQ-011 SHALL have port out_valid, output, 1, head entry present.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts head.
REQ-013 SHALL have port level, output, clog2(DEPTH)+1, current occupancy.

Function
REQ-014 SHALL push when in_valid && in_ready && !flush, writing in_data to entry at write pointer, then incrementing the write pointer modulo DEPTH.
REQ-015 SHALL pop when out_valid && out_ready && !flush, then increment the read pointer modulo DEPTH and zero the popped entry in the same edge.
REQ-016 SHALL drive in_ready = (level != DEPTH), registered-state only, with no combinational dependence on out_ready.
REQ-017 SHALL drive out_valid = (level != 0), registered-state only.
REQ-018 SHALL drive out_data from the stored entry at the read pointer when out_valid=1, and all-zero when out_valid=0.
REQ-019 SHALL give a push-to-output latency of 1 cycle; an entry pushed at edge N is visible on out_data/out_valid after edge N, with no same-cycle fall-through.
REQ-020 SHALL, on simultaneous push and pop, leave level unchanged and advance both pointers.
REQ-021 SHALL, when full, ignore in_valid with no overwrite even if a pop occurs in that cycle; the slot frees for the next cycle.
REQ-022 SHALL, when empty, ignore out_ready, leaving pointers and level unchanged.
REQ-023 SHALL update level as +1 on push-only, -1 on pop-only, and unchanged otherwise; level SHALL never exceed DEPTH or go below 0.
REQ-024 SHALL give flush priority over push and pop: next state has pointers=0, level=0, and all entries zero; in_data presented with flush is discarded.
REQ-025 SHALL never combine shares of one bit (no XOR or AND across shares); share i of bit j is stored and output at the same index.
REQ-026 SHALL have pointer wrap-around that is transparent, preserving FIFO order across wrap.

Reset
REQ-027 SHALL, while rst_n=0, immediately (without clk) force pointers=0, level=0, all entries zero, in_ready=1, out_valid=0, and out_data=0.
REQ-028 SHALL resume normal operation on the first rising clk edge after rst_n deasserts; reset mid-burst loses all stored entries.

Verification
REQ-029 SHALL pass this scenario: d=2, count=8, DEPTH=4; push 0xA55A, 0x1234, 0xFFFF with out_ready=0 -> level=3, out_data=0xA55A; then out_ready=1 for 3 cycles -> outputs in order 0xA55A, 0x1234, 0xFFFF, then out_valid=0 and out_data=0.
REQ-030 SHALL pass this scenario: push 5 entries continuously with out_ready=0 -> 4 accepted, in_ready=0 at level=4, and the 5th held by the source and accepted one cycle after the first pop.
REQ-031 SHALL pass this scenario: level=2, in_valid=1, out_ready=1 for 10 cycles with an incrementing pattern -> level stays 2 and output order is intact across two pointer wraps.
REQ-032 SHALL pass this scenario: level=3, assert flush with in_valid=1 and out_ready=1 -> next cycle level=0, out_valid=0, out_data=0, and the flush-cycle in_data is not stored.
REQ-033 SHALL pass this scenario: level=3, pulse rst_n low between clk edges -> outputs and level zero before the next edge, and a subsequent push of 0x0F0F appears with 1-cycle latency.
REQ-034 SHALL pass this scenario: random push/pop over 10k cycles against a reference queue model -> data match, zero-when-empty holds, and level stays within bounds at every cycle.
